// File: rtl/onewire_master.sv
// onewire_master: 1-Wire bus initiator at standard speed.
// Generates reset/presence, write and read time slots on an open-drain bus and
// exchanges whole bytes (LSB first on the wire) with the host via a simple
// command/response handshake.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   IO_i              raw bus level (synchronised internally)
//   IO_o              1 = pull bus low, 0 = release
//   cmd_valid/ready   command handshake; cmd_op 00 RESET, 01 WRITE_BYTE,
//                     10 READ_BYTE, 11 TOUCH_BIT; cmd_data write byte / touch bit 0
//   rsp_valid         one-cycle completion pulse
//   rsp_data          read byte, or touch sample in bit 0
//   rsp_presence      presence pulse seen during RESET
//   rsp_stuck         bus still low at the end of the final slot / recovery
//   busy              command in progress
//   crc8              (only with OW_CRC8_EN) running Dallas CRC-8 of byte traffic
//
// Build option: define OW_CRC8_EN to add the crc8 port and CRC logic.
module onewire_master #(
  parameter int unsigned CLKS_PER_US = 50,
  parameter int unsigned T_RSTL_US   = 480,
  parameter int unsigned T_PDS_US    = 70,
  parameter int unsigned T_RSTR_US   = 410,
  parameter int unsigned T_SLOT_US   = 70,
  parameter int unsigned T_LOW1_US   = 6,
  parameter int unsigned T_LOW0_US   = 60,
  parameter int unsigned T_RDS_US    = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       IO_i,
  output logic       IO_o,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_presence,
  output logic       rsp_stuck,
  output logic       busy
`ifdef OW_CRC8_EN
  ,
  output logic [7:0] crc8
`endif
);

  localparam int unsigned PreW = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
  localparam int unsigned UsW  = 10;

  localparam logic [1:0] OpReset = 2'b00;
  localparam logic [1:0] OpWrite = 2'b01;
  localparam logic [1:0] OpRead  = 2'b10;
  localparam logic [1:0] OpTouch = 2'b11;

  typedef enum logic [2:0] {
    StIdle, StRstLow, StRstWait, StRstRecov, StSlotLow, StSlotRel, StSlotRec, StDone
  } state_e;

  state_e             state_q, state_d;
  logic [PreW-1:0]    pre_q;
  logic [UsW-1:0]     us_q, us_d;
  logic               meta_q, sync_q;
  logic [1:0]         op_q, op_d;
  logic [7:0]         data_q, data_d;
  logic [2:0]         bit_q, bit_d;
  logic               pres_q, pres_d;
  logic [7:0]         rsp_data_q, rsp_data_d;
  logic               rsp_pres_q, rsp_pres_d;
  logic               rsp_stuck_q, rsp_stuck_d;
  logic               tick;
  logic [UsW-1:0]     low_len;

  // Free-running prescaler, so phase starts jitter by less than 1 us.
  assign tick = (pre_q == PreW'(CLKS_PER_US - 1));

  // Read slots are loaded with 8'hFF, so data_q[0]==0 only for a real write-0.
  assign low_len = data_q[0] ? UsW'(T_LOW1_US) : UsW'(T_LOW0_US);

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    data_d      = data_q;
    bit_d       = bit_q;
    pres_d      = pres_q;
    rsp_data_d  = rsp_data_q;
    rsp_pres_d  = rsp_pres_q;
    rsp_stuck_d = rsp_stuck_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          op_d        = cmd_op;
          bit_d       = 3'd0;
          data_d      = (cmd_op == OpRead) ? 8'hFF : cmd_data;
          rsp_data_d  = 8'h00;
          rsp_pres_d  = 1'b0;
          rsp_stuck_d = 1'b0;
          state_d     = (cmd_op == OpReset) ? StRstLow : StSlotLow;
        end
      end
      StRstLow: begin
        if (tick && us_q == UsW'(T_RSTL_US - 1)) state_d = StRstWait;
      end
      StRstWait: begin
        if (tick && us_q == UsW'(T_PDS_US - 1)) begin
          pres_d  = ~sync_q;
          state_d = StRstRecov;
        end
      end
      StRstRecov: begin
        if (tick && us_q == UsW'(T_RSTR_US - 1)) begin
          rsp_pres_d  = pres_q;
          rsp_stuck_d = ~sync_q;
          state_d     = StDone;
        end
      end
      StSlotLow: begin
        if (tick && us_q == low_len - UsW'(1)) state_d = StSlotRel;
      end
      StSlotRel: begin
        // A write-0 low phase already extends past the sample point: leave at once.
        if (us_q >= UsW'(T_RDS_US) || (tick && us_q == UsW'(T_RDS_US - 1))) begin
          data_d  = {sync_q, data_q[7:1]};
          state_d = StSlotRec;
        end
      end
      StSlotRec: begin
        if (tick && us_q == UsW'(T_SLOT_US - 1)) begin
          if (op_q == OpTouch || bit_q == 3'd7) begin
            rsp_stuck_d = ~sync_q;
            unique case (op_q)
              OpRead:  rsp_data_d = data_q;
              OpTouch: rsp_data_d = {7'b0, data_q[7]};
              default: rsp_data_d = 8'h00;
            endcase
            state_d = StDone;
          end else begin
            bit_d   = bit_q + 3'd1;
            state_d = StSlotLow;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Slot sub-phases keep the timer running so it measures time from slot start.
  always_comb begin
    us_d = us_q;
    if (state_q == StIdle ||
        (state_d != state_q && state_d != StSlotRel && state_d != StSlotRec)) begin
      us_d = '0;
    end else if (tick) begin
      us_d = us_q + UsW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      pre_q       <= '0;
      us_q        <= '0;
      meta_q      <= 1'b1;
      sync_q      <= 1'b1;
      op_q        <= OpReset;
      data_q      <= 8'h00;
      bit_q       <= 3'd0;
      pres_q      <= 1'b0;
      rsp_data_q  <= 8'h00;
      rsp_pres_q  <= 1'b0;
      rsp_stuck_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pre_q       <= tick ? '0 : pre_q + PreW'(1);
      us_q        <= us_d;
      meta_q      <= IO_i;
      sync_q      <= meta_q;
      op_q        <= op_d;
      data_q      <= data_d;
      bit_q       <= bit_d;
      pres_q      <= pres_d;
      rsp_data_q  <= rsp_data_d;
      rsp_pres_q  <= rsp_pres_d;
      rsp_stuck_q <= rsp_stuck_d;
    end
  end

`ifdef OW_CRC8_EN
  logic [7:0] crc_q, crc_d;
  logic       crc_fb;

  // Reflected x^8+x^5+x^4+1, one wire bit per update (written bit or read bit).
  always_comb begin
    crc_d  = crc_q;
    crc_fb = crc_q[0] ^ ((op_q == OpRead) ? sync_q : data_q[0]);
    if (state_q == StIdle && cmd_valid && cmd_op == OpReset) begin
      crc_d = 8'h00;
    end else if (state_q == StSlotRel && state_d == StSlotRec && op_q != OpTouch) begin
      crc_d = {1'b0, crc_q[7:1]} ^ (crc_fb ? 8'h8C : 8'h00);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) crc_q <= 8'h00;
    else     crc_q <= crc_d;
  end

  assign crc8 = crc_q;
`endif

  assign IO_o         = (state_q == StRstLow) || (state_q == StSlotLow);
  assign busy         = (state_q != StIdle);
  assign cmd_ready    = ~busy;
  assign rsp_valid    = (state_q == StDone);
  assign rsp_data     = rsp_data_q;
  assign rsp_presence = rsp_pres_q;
  assign rsp_stuck    = rsp_stuck_q;

endmodule

// File: tb/tb_onewire_master.sv
// Bench for onewire_master at CLKS_PER_US=4 with a scripted responder on the bus.
// Expected responses are queued when a command is issued and compared when
// rsp_valid fires; slot timing is measured from the IO_o waveform.
module tb_onewire_master;

  localparam int Cpu = 4;
  localparam logic [1:0] OpReset = 2'b00;
  localparam logic [1:0] OpWrite = 2'b01;
  localparam logic [1:0] OpRead  = 2'b10;
  localparam logic [1:0] OpTouch = 2'b11;

  typedef struct packed {
    logic [7:0] data;
    logic       chk_data;
    logic       pres;
    logic       stuck;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       IO_i, IO_o;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [7:0] cmd_data = 8'h00;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_presence, rsp_stuck, busy;
`ifdef OW_CRC8_EN
  logic [7:0] crc8;
`endif

  logic pres_en = 1'b0;
  logic ext_low = 1'b0;
  logic pres_pull, rd_pull;

  int   n_cmp = 0;
  int   n_err = 0;

  onewire_master #(.CLKS_PER_US(Cpu)) dut (
    .clk          (clk),
    .rst          (rst),
    .IO_i         (IO_i),
    .IO_o         (IO_o),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_data     (cmd_data),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .rsp_presence (rsp_presence),
    .rsp_stuck    (rsp_stuck),
    .busy         (busy)
`ifdef OW_CRC8_EN
    ,
    .crc8         (crc8)
`endif
  );

  always #5 clk = ~clk;

  // Wired-AND bus: anyone pulling makes it low.
  assign IO_i = ~(IO_o | pres_pull | rd_pull | ext_low);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Responder: presence pulse after a long reset low; read bits pulled low for 30 us.
  int   pres_t = -1;
  int   hi_cnt = 0;
  int   rd_cnt = 0;
  logic io_o_p = 1'b0;
  logic rd_q[$];

  always @(posedge clk) begin
    io_o_p <= IO_o;
    hi_cnt <= IO_o ? hi_cnt + 1 : 0;
    if (pres_en && !IO_o && io_o_p && hi_cnt >= 400 * Cpu) pres_t <= 0;
    else if (pres_t >= 0) pres_t <= (pres_t >= 200 * Cpu) ? -1 : pres_t + 1;
    if (IO_o && !io_o_p && rd_q.size() > 0) rd_cnt <= rd_q.pop_front() ? 0 : 30 * Cpu;
    else if (rd_cnt > 0) rd_cnt <= rd_cnt - 1;
  end

  // Responder waits 30 us after release, then holds the bus low until 200 us.
  assign pres_pull = (pres_t >= 30 * Cpu) && (pres_t < 200 * Cpu);
  assign rd_pull   = (rd_cnt > 0);

  // Monitor and scoreboard, sampled on the falling edge.
  int   cyc = 0;
  int   rise_t = 0;
  int   n_rsp = 0;
  int   rsp_t = 0;
  int   n_acc = 0;
  logic mon_p = 1'b0;
  int   rise_q[$];
  int   low_q[$];
  exp_t sb_q[$];

  always @(negedge clk) begin
    cyc   <= cyc + 1;
    mon_p <= IO_o;
    if (IO_o && !mon_p) begin
      rise_t <= cyc;
      rise_q.push_back(cyc);
    end
    if (!IO_o && mon_p) low_q.push_back(cyc - rise_t);
    if (cmd_valid && cmd_ready && !rst) n_acc <= n_acc + 1;
    if (rsp_valid) begin
      n_rsp <= n_rsp + 1;
      rsp_t <= cyc;
      check("sb_pending", 32'(sb_q.size() > 0), 32'd1);
      if (sb_q.size() > 0) begin
        if (sb_q[0].chk_data) check("rsp_data", 32'(rsp_data), 32'(sb_q[0].data));
        check("rsp_presence", 32'(rsp_presence), 32'(sb_q[0].pres));
        check("rsp_stuck", 32'(rsp_stuck), 32'(sb_q[0].stuck));
        void'(sb_q.pop_front());
      end
    end
  end

  task automatic run_cmd(input logic [1:0] op, input logic [7:0] data, input logic [7:0] e_data,
                         input logic e_chk, input logic e_pres, input logic e_stuck,
                         output int lat);
    int n0, t0, k;
    sb_q.push_back({e_data, e_chk, e_pres, e_stuck});
    n0 = n_rsp;
    @(negedge clk);
    cmd_op    = op;
    cmd_data  = data;
    cmd_valid = 1'b1;
    k = 0;
    while (!cmd_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    t0 = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
    k = 0;
    while (n_rsp == n0 && k < 6000) begin
      @(negedge clk);
      k++;
    end
    check("rsp_arrived", 32'(n_rsp != n0), 32'd1);
    lat = rsp_t - t0;
  endtask

  task automatic push_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) rd_q.push_back(b[i]);
  endtask

`ifdef OW_CRC8_EN
  function automatic logic [7:0] crc_upd(input logic [7:0] c, input logic [7:0] b);
    logic [7:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = {1'b0, r[7:1]} ^ ((r[0] ^ b[i]) ? 8'h8C : 8'h00);
    return r;
  endfunction
`endif

  initial begin
    int lat, n0, a0;
    logic [7:0] wr_byte;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_io_o", 32'(IO_o), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_rsp_presence", 32'(rsp_presence), 32'd0);
    check("rst_rsp_stuck", 32'(rsp_stuck), 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // RESET with responder present
    pres_en = 1'b1;
    low_q.delete();
    run_cmd(OpReset, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, lat);
    check("rst_low_us", 32'((low_q.size() > 0) ? (low_q[0] + 3) / Cpu : 0), 32'd480);

    // RESET with nobody on the bus
    pres_en = 1'b0;
    run_cmd(OpReset, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, lat);
    check("rst_latency_960us", 32'((lat / Cpu) >= 955 && (lat / Cpu) <= 965), 32'd1);
    check("rst_bus_released", 32'(IO_o), 32'd0);
    check("rst_idle_ready", 32'(cmd_ready), 32'd1);
    pres_en = 1'b1;

    // WRITE_BYTE 0xCC: slot low times and spacing
    wr_byte = 8'hCC;
    rise_q.delete();
    low_q.delete();
    n0 = n_rsp;
    run_cmd(OpWrite, wr_byte, 8'h00, 1'b0, 1'b0, 1'b0, lat);
    repeat (20 * Cpu) @(negedge clk);
    check("wr_rsp_once", 32'(n_rsp - n0), 32'd1);
    check("wr_slot_count", 32'(rise_q.size()), 32'd8);
    if (low_q.size() == 8 && rise_q.size() == 8) begin
      for (int i = 0; i < 8; i++)
        check($sformatf("wr_low_us_%0d", i), 32'((low_q[i] + 3) / Cpu),
              wr_byte[i] ? 32'd6 : 32'd60);
      for (int i = 0; i < 7; i++)
        check($sformatf("wr_slot_us_%0d", i), 32'((rise_q[i + 1] - rise_q[i] + 3) / Cpu),
              32'd70);
    end

    // READ_BYTE with responder sending 0xA5
    push_byte(8'hA5);
    run_cmd(OpRead, 8'h00, 8'hA5, 1'b1, 1'b0, 1'b0, lat);
    check("rd_bits_consumed", 32'(rd_q.size()), 32'd0);

    // TOUCH_BIT 1 on an idle bus reads back 1
    run_cmd(OpTouch, 8'h01, 8'h01, 1'b1, 1'b0, 1'b0, lat);

    // TOUCH_BIT 1 with the bus held low externally
    ext_low = 1'b1;
    run_cmd(OpTouch, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1, lat);
    ext_low = 1'b0;
    repeat (10) @(negedge clk);

    // cmd_valid held during busy, rst pulsed mid-slot
    n0 = n_rsp;
    a0 = n_acc;
    @(negedge clk);
    cmd_op    = OpWrite;
    cmd_data  = 8'h00;
    cmd_valid = 1'b1;
    repeat (100 * Cpu) @(negedge clk);
    check("midop_bus_low", 32'(IO_o), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midop_rst_io_o", 32'(IO_o), 32'd0);
    check("midop_rst_busy", 32'(busy), 32'd0);
    cmd_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (200 * Cpu) @(negedge clk);
    check("midop_accepts", 32'(n_acc - a0), 32'd1);
    check("midop_no_rsp", 32'(n_rsp - n0), 32'd0);

`ifdef OW_CRC8_EN
    begin
      logic [7:0] rom [8];
      logic [7:0] c;
      rom[0] = 8'h28; rom[1] = 8'h11; rom[2] = 8'h22; rom[3] = 8'h33;
      rom[4] = 8'h44; rom[5] = 8'h55; rom[6] = 8'h66;
      c = 8'h00;
      for (int i = 0; i < 7; i++) c = crc_upd(c, rom[i]);
      rom[7] = c;
      run_cmd(OpReset, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, lat);
      check("crc_cleared", 32'(crc8), 32'd0);
      for (int i = 0; i < 8; i++) begin
        push_byte(rom[i]);
        run_cmd(OpRead, 8'h00, rom[i], 1'b1, 1'b0, 1'b0, lat);
      end
      check("crc_rom_zero", 32'(crc8), 32'd0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
